pll_sequencer: RTL and testbench

PLL_SEQUENCER -- requirements
Module: pll_sequencer

---
 rtl/pll_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pll_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_sequencer.sv
// Sequences PLL reconfiguration: deselect the PLL clock, hold the PLL in reset
// while new settings are applied, wait for lock, then reselect the PLL clock.
module pll_sequencer #(
    parameter int RESET_CYCLES  = 8,
    parameter int SETTLE_CYCLES = 1024,
    parameter int SWITCH_CYCLES = 4
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_enable,
    input  logic        cfg_dco,
    input  logic [4:0]  cfg_div,
    input  logic [25:0] cfg_trim,
    output logic        pll_resetb,
    output logic        pll_enable,
    output logic        pll_dco,
    output logic [4:0]  pll_div,
    output logic [25:0] pll_trim,
    output logic        sel_pll,
    output logic        locked
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DESEL  = 2'd1,
        HOLD   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    // Counters are loaded with N-1 so each phase lasts exactly N cycles.
    localparam logic [15:0] SWITCH_LOAD = 16'(SWITCH_CYCLES - 1);
    localparam logic [15:0] RESET_LOAD  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    state_t      state_q;
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic        countZero;

    logic        latEnable_q;
    logic        latDco_q;
    logic [4:0]  latDiv_q;
    logic [25:0] latTrim_q;

    logic        ready_q;
    logic        pllResetb_q;
    logic        pllEnable_q;
    logic        pllDco_q;
    logic [4:0]  pllDiv_q;
    logic [25:0] pllTrim_q;
    logic        selPll_q;
    logic        locked_q;

    assign countZero = (count_q == 16'd0);

    always_comb begin
        count_d = count_q;
        if (!countZero) begin
            count_d = count_q - 16'd1;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= IDLE;
            count_q     <= 16'd0;
            latEnable_q <= 1'b0;
            latDco_q    <= 1'b0;
            latDiv_q    <= 5'd0;
            latTrim_q   <= 26'd0;
            ready_q     <= 1'b1;
            pllResetb_q <= 1'b0;
            pllEnable_q <= 1'b0;
            pllDco_q    <= 1'b0;
            pllDiv_q    <= 5'd0;
            pllTrim_q   <= 26'd0;
            selPll_q    <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        latEnable_q <= cfg_enable;
                        latDco_q    <= cfg_dco;
                        latDiv_q    <= cfg_div;
                        latTrim_q   <= cfg_trim;
                        ready_q     <= 1'b0;
                        locked_q    <= 1'b0;
                        // The core must be off the PLL clock before the PLL is touched.
                        if (selPll_q) begin
                            state_q  <= DESEL;
                            selPll_q <= 1'b0;
                            count_q  <= SWITCH_LOAD;
                        end else begin
                            state_q     <= HOLD;
                            count_q     <= RESET_LOAD;
                            pllResetb_q <= 1'b0;
                            pllEnable_q <= 1'b0;
                            pllDco_q    <= cfg_dco;
                            pllDiv_q    <= cfg_div;
                            pllTrim_q   <= cfg_trim;
                        end
                    end
                end
                DESEL: begin
                    if (countZero) begin
                        state_q     <= HOLD;
                        count_q     <= RESET_LOAD;
                        pllResetb_q <= 1'b0;
                        pllEnable_q <= 1'b0;
                        pllDco_q    <= latDco_q;
                        pllDiv_q    <= latDiv_q;
                        pllTrim_q   <= latTrim_q;
                    end else begin
                        count_q <= count_d;
                    end
                end
                HOLD: begin
                    if (countZero) begin
                        if (latEnable_q) begin
                            state_q     <= SETTLE;
                            count_q     <= SETTLE_LOAD;
                            pllResetb_q <= 1'b1;
                            pllEnable_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            count_q <= 16'd0;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        count_q <= count_d;
                    end
                end
                SETTLE: begin
                    if (countZero) begin
                        state_q  <= IDLE;
                        count_q  <= 16'd0;
                        ready_q  <= 1'b1;
                        selPll_q <= 1'b1;
                        locked_q <= 1'b1;
                    end else begin
                        count_q <= count_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= 16'd0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready  = ready_q;
    assign pll_resetb = pllResetb_q;
    assign pll_enable = pllEnable_q;
    assign pll_dco    = pllDco_q;
    assign pll_div    = pllDiv_q;
    assign pll_trim   = pllTrim_q;
    assign sel_pll    = selPll_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_pll_sequencer.sv
// Bench for pll_sequencer: a timeline model (cycles since acceptance) predicts
// every output each cycle; directed phases pin key instants with literals.
module tb_pll_sequencer;

    localparam int SW = 4;
    localparam int RC = 8;
    localparam int SC = 1024;

    logic        clock;
    logic        resetb;
    logic        cfgValid;
    logic        cfgReady;
    logic        cfgEnable;
    logic        cfgDco;
    logic [4:0]  cfgDiv;
    logic [25:0] cfgTrim;
    logic        pllResetb;
    logic        pllEnable;
    logic        pllDco;
    logic [4:0]  pllDiv;
    logic [25:0] pllTrim;
    logic        selPll;
    logic        locked;
    logic [36:0] outVec;

    int compared   = 0;
    int mismatched = 0;

    // Model: expected outputs plus the active sequence described as an offset in cycles.
    bit          mActive;
    int          mK;
    int          mDesel;
    bit          lEn;
    bit          lDco;
    logic [4:0]  lDiv;
    logic [25:0] lTrim;
    logic        eReady, eRstb, eEn, eDco, eSel, eLocked;
    logic [4:0]  eDiv;
    logic [25:0] eTrim;

    pll_sequencer #(
        .RESET_CYCLES (RC),
        .SETTLE_CYCLES(SC),
        .SWITCH_CYCLES(SW)
    ) dut (
        .clock     (clock),
        .resetb    (resetb),
        .cfg_valid (cfgValid),
        .cfg_ready (cfgReady),
        .cfg_enable(cfgEnable),
        .cfg_dco   (cfgDco),
        .cfg_div   (cfgDiv),
        .cfg_trim  (cfgTrim),
        .pll_resetb(pllResetb),
        .pll_enable(pllEnable),
        .pll_dco   (pllDco),
        .pll_div   (pllDiv),
        .pll_trim  (pllTrim),
        .sel_pll   (selPll),
        .locked    (locked)
    );

    assign outVec = {cfgReady, pllResetb, pllEnable, pllDco, pllDiv, pllTrim, selPll, locked};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic modelReset();
        mActive = 1'b0;
        mK      = 0;
        mDesel  = 0;
        eReady  = 1'b1;
        eRstb   = 1'b0;
        eEn     = 1'b0;
        eDco    = 1'b0;
        eDiv    = 5'd0;
        eTrim   = 26'd0;
        eSel    = 1'b0;
        eLocked = 1'b0;
    endtask

    task automatic modelStep();
        if (!mActive) begin
            if (cfgValid) begin
                mActive = 1'b1;
                mK      = 0;
                mDesel  = eSel ? SW : 0;
                lEn     = cfgEnable;
                lDco    = cfgDco;
                lDiv    = cfgDiv;
                lTrim   = cfgTrim;
            end
        end else begin
            mK++;
        end
        if (mActive) begin
            eReady  = 1'b0;
            eSel    = 1'b0;
            eLocked = 1'b0;
            if (mK >= mDesel + RC + (lEn ? SC : 0)) begin
                eReady  = 1'b1;
                eRstb   = lEn;
                eEn     = lEn;
                eSel    = lEn;
                eLocked = lEn;
                mActive = 1'b0;
            end else if (mK >= mDesel + RC) begin
                eRstb = 1'b1;
                eEn   = 1'b1;
            end else if (mK >= mDesel) begin
                eRstb = 1'b0;
                eEn   = 1'b0;
                eDco  = lDco;
                eDiv  = lDiv;
                eTrim = lTrim;
            end
        end
    endtask

    // Single compare process: every edge (clock or async reset) advances the model then checks.
    initial begin
        logic [36:0] expVec;
        logic [31:0] prevCfg;
        logic [31:0] curCfg;
        prevCfg = '0;
        modelReset();
        forever begin
            @(posedge clock or negedge resetb);
            if (resetb !== 1'b1) modelReset();
            else modelStep();
            #1;
            expVec = {eReady, eRstb, eEn, eDco, eDiv, eTrim, eSel, eLocked};
            compared++;
            if (outVec !== expVec) begin
                mismatched++;
                $display("[TB] FAIL cycleModel t=%0t actual=%h required=%h", $time, outVec, expVec);
            end
            compared++;
            if (selPll === 1'b1 && (pllResetb !== 1'b1 || pllEnable !== 1'b1)) begin
                mismatched++;
                $display("[TB] FAIL selSafety t=%0t actual sel=%b rstb=%b en=%b required sel=0 unless rstb=en=1",
                         $time, selPll, pllResetb, pllEnable);
            end
            curCfg = {pllDco, pllDiv, pllTrim};
            compared++;
            if (curCfg !== prevCfg && pllEnable !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL cfgStable t=%0t actual cfg=%h en=%b required change only with en=0",
                         $time, curCfg, pllEnable);
            end
            prevCfg = curCfg;
        end
    end

    task automatic applyStimulus(input logic valid, input logic en, input logic dco,
                                 input logic [4:0] div, input logic [25:0] trim);
        cfgValid  = valid;
        cfgEnable = en;
        cfgDco    = dco;
        cfgDiv    = div;
        cfgTrim   = trim;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input logic [36:0] actual, input logic [36:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    initial begin
        resetb = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 26'd0);
        waitCycles(3);
        checkOutput("resetState", outVec, {1'b1, 36'd0});

        $display("[TB] first request right after reset release, div=8");
        resetb = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd8, 26'd0);
        waitCycles(1);
        checkOutput("holdEntry rdy/rstb/en/div", {cfgReady, pllResetb, pllEnable, pllDiv}, {1'b0, 1'b0, 1'b0, 5'd8});
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd8, 26'd0);
        waitCycles(7);
        checkOutput("holdLast rstb", pllResetb, 1'b0);
        waitCycles(1);
        checkOutput("settleEntry rstb/en", {pllResetb, pllEnable}, 2'b11);
        waitCycles(SC - 1);
        checkOutput("settleLast rdy/sel/lock", {cfgReady, selPll, locked}, 3'b000);
        waitCycles(1);
        checkOutput("lockEdge rdy/sel/lock", {cfgReady, selPll, locked}, 3'b111);
        checkOutput("modelLock", {eSel, eLocked}, 2'b11);

        $display("[TB] reconfigure from locked, div=5");
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd5, 26'd0);
        waitCycles(1);
        checkOutput("deselEntry sel/lock/en/div", {selPll, locked, pllEnable, pllDiv}, {1'b0, 1'b0, 1'b1, 5'd8});
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 26'd0);
        waitCycles(3);
        checkOutput("deselLast en/div", {pllEnable, pllDiv}, {1'b1, 5'd8});
        waitCycles(1);
        checkOutput("holdEntry2 en/div", {pllEnable, pllDiv}, {1'b0, 5'd5});
        waitCycles(7);
        checkOutput("holdLast2 en", pllEnable, 1'b0);
        waitCycles(1);
        checkOutput("settleEntry2 en", pllEnable, 1'b1);
        waitCycles(SC);
        checkOutput("relock sel/lock", {selPll, locked}, 2'b11);

        $display("[TB] disable from locked");
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd9, 26'd0);
        waitCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 5'd1, 26'd7);
        waitCycles(11);
        checkOutput("disableEdge12 rdy", cfgReady, 1'b0);
        waitCycles(1);
        checkOutput("disableDone", outVec, {1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 26'd0, 1'b0, 1'b0});

        $display("[TB] DCO mode with full trim");
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd2, 26'h3FFFFFF);
        waitCycles(1);
        checkOutput("dcoHoldEntry", outVec, {1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 26'h3FFFFFF, 1'b0, 1'b0});
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 26'd0);
        waitCycles(RC + SC);
        checkOutput("dcoLock sel/lock", {selPll, locked}, 2'b11);

        $display("[TB] reset pulse during settle");
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 26'd5);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 26'd0);
        waitCycles(SW + RC + 100);
        #3 resetb = 1'b0;
        #1 checkOutput("asyncReset", outVec, {1'b1, 36'd0});
        @(negedge clock);
        resetb = 1'b1;
        waitCycles(SC + 80);
        checkOutput("noResume", outVec, {1'b1, 36'd0});

        $display("[TB] cfg_valid held high, div toggling");
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd4, 26'd11);
        for (int i = 0; i < 3200; i++) begin
            waitCycles(1);
            if ($urandom_range(0, 3) == 0) cfgDiv = 5'($urandom());
            if ($urandom_range(0, 7) == 0) cfgEnable = ~cfgEnable;
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 16000; i++) begin
            applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 4) != 0,
                          1'($urandom()), 5'($urandom()), 26'($urandom()));
            if ($urandom_range(0, 2999) == 0) begin
                #3 resetb = 1'b0;
                @(negedge clock);
                resetb = 1'b1;
            end else begin
                waitCycles(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
